// File: rtl/code_sender_pkg.sv
// Shared types and constants for the BCD code sender.
package code_sender_pkg;

  localparam int DIGIT_W   = 4;
  localparam int MAX_DIGIT = 9;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    FIN
  } state_e;

  // A BCD digit is legal when it does not exceed 9.
  function automatic logic digit_ok(input logic [DIGIT_W-1:0] d);
    return d <= DIGIT_W'(MAX_DIGIT);
  endfunction

endpackage

// File: rtl/code_sender_if.sv
// Start/busy/done handshake plus digit stream between controller and sender.
interface code_sender_if
  import code_sender_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);

  logic                          start;
  logic [DIGIT_W*NUM_DIGITS-1:0] code;
  logic [DIGIT_W-1:0]            dec;
  logic                          dec_valid;
  logic                          busy;
  logic                          done;
  logic                          err;

  modport master (output start, code, input dec, dec_valid, busy, done, err);
  modport slave  (input start, code, output dec, dec_valid, busy, done, err);

endinterface

// File: rtl/code_sender_cksum.sv
// Mod-10 running sum of the transmitted digits; its value is the check digit.
module code_sender_cksum
  import code_sender_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               add,
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] check
);

  logic [4:0] acc_q, acc_d;
  logic [4:0] sum;

  // Add the new digit to the (optionally cleared) sum and reduce mod 10.
  always_comb begin
    sum   = (clr ? 5'd0 : acc_q) + (add ? {1'b0, digit} : 5'd0);
    acc_d = (sum >= 5'd10) ? sum - 5'd10 : sum;
  end

  // Accumulator register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign check = acc_q[DIGIT_W-1:0];

endmodule

// File: rtl/code_sender.sv
// Serializes a stored BCD code onto dec, most significant digit first.
// Optional feature: define CODE_SENDER_CHECK_EN to append a mod-10 check digit.
module code_sender
  import code_sender_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic          clk,
  input  logic          rst,
  code_sender_if.slave  bus
);

  localparam int CODE_W = DIGIT_W * NUM_DIGITS;
  localparam int CNT_W  = $clog2(NUM_DIGITS + 2);
  localparam int GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
`ifdef CODE_SENDER_CHECK_EN
  localparam int TOTAL = NUM_DIGITS + 1;
  localparam logic [CNT_W-1:0] DATA_CNT = CNT_W'(NUM_DIGITS);
`else
  localparam int TOTAL = NUM_DIGITS;
`endif
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TOTAL);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;     // digits already placed on dec
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [DIGIT_W-1:0]  dec_q, dec_d;
  logic                dec_valid_q, dec_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                code_ok;
  logic                load_first, load_next;
  logic [DIGIT_W-1:0]  next_digit;

  // A start is accepted only if every digit of the offered code is BCD.
  always_comb begin
    code_ok = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!digit_ok(bus.code[i*DIGIT_W +: DIGIT_W])) code_ok = 1'b0;
    end
  end

`ifdef CODE_SENDER_CHECK_EN
  logic [DIGIT_W-1:0] check_digit;

  code_sender_cksum u_cksum (
    .clk   (clk),
    .rst   (rst),
    .clr   (load_first),
    .add   (load_first | load_next),
    .digit (dec_d),
    .check (check_digit)
  );

  // After the data digits are exhausted the check digit goes out.
  assign next_digit = (cnt_q == DATA_CNT) ? check_digit : buf_q[CODE_W-1 -: DIGIT_W];
`else
  assign next_digit = buf_q[CODE_W-1 -: DIGIT_W];
`endif

  // Next-state and next-output logic; outputs are prepared one cycle ahead
  // so every port comes straight from a flop.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned (no latches).
    state_d     = state_q;
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    dec_d       = '0;
    dec_valid_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    load_first  = 1'b0;
    load_next   = 1'b0;

    case (state_q)
      // FIN behaves like IDLE for start so transactions can run back to back.
      IDLE, FIN: begin
        state_d = IDLE;
        if (bus.start) begin
          if (code_ok) begin
            load_first  = 1'b1;
            state_d     = SEND;
            dec_d       = bus.code[CODE_W-1 -: DIGIT_W];
            dec_valid_d = 1'b1;
            busy_d      = 1'b1;
            buf_d       = bus.code << DIGIT_W;
            cnt_d       = CNT_W'(1);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (cnt_q == LAST_CNT) begin
          state_d = FIN;
          done_d  = 1'b1;
        end else if (GAP_CYCLES > 0) begin
          state_d = GAP;
          gap_d   = '0;
          busy_d  = 1'b1;
        end else begin
          load_next = 1'b1;
        end
      end
      GAP: begin
        busy_d = 1'b1;
        if (gap_q == GAP_LAST) load_next = 1'b1;
        else                   gap_d = gap_q + GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase

    if (load_next) begin
      state_d     = SEND;
      dec_d       = next_digit;
      dec_valid_d = 1'b1;
      busy_d      = 1'b1;
      buf_d       = buf_q << DIGIT_W;
      cnt_d       = cnt_q + CNT_W'(1);
    end
  end

  // State, shift buffer, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the shift buffer is reset too; it is small and must read as cleared after reset.
    if (rst) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      dec_q       <= '0;
      dec_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops update together from pre-edge values.
      state_q     <= state_d;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      dec_q       <= dec_d;
      dec_valid_q <= dec_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.dec       = dec_q;
  assign bus.dec_valid = dec_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: doc/code_sender.md
# code_sender

Transmit end of the digit-entry interface: serializes a stored multi-digit BCD code into a one-digit-per-slot stream on `dec`, most significant digit first. The stream is the input the lock module expects. Used as a test/key-fob source and as the programmable code entry path. Start/busy/done handshake toward the controller; `dec_valid` qualifies each emitted digit.

## Interface
- `NUM_DIGITS`, default 4: number of code digits sent per transaction (1–8).
- `GAP_CYCLES`, default 0: idle cycles inserted between consecutive digits. Must be 0 when driving the lock directly, because the lock shifts on every clock.
- `clk`  input  1: single clock, rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `start`  input  1: request to send; sampled only when `busy`=0.
- `code`  input  4*NUM_DIGITS: BCD digits; digit 0 is `code[4*NUM_DIGITS-1 -: 4]` and is sent first. Sampled on the accepted `start` edge.
- `dec`  output  4: current digit; 0 whenever `dec_valid`=0.
- `dec_valid`  output  1: `dec` holds a transmitted digit this cycle.
- `busy`  output  1: a transaction is in progress.
- `done`  output  1: one-cycle pulse after the last digit.
- `err`  output  1: one-cycle pulse when a start is rejected.

## Operation
- The FSM has four states: IDLE, SEND, GAP, FIN.
- IDLE with `start`=1 and all digits ≤ 9:
  - latch `code` into the shift buffer;
  - clear the digit counter;
  - go to SEND.
- IDLE with `start`=1 and any digit > 9:
  - pulse `err` next cycle;
  - stay in IDLE;
  - no `dec_valid`.
- SEND:
  - drive the buffer's top digit with `dec_valid`=1;
  - shift the buffer left by 4 bits and increment the counter.
  - If the digit sent was the last one, go to FIN.
  - Otherwise go to GAP if `GAP_CYCLES`>0, else stay in SEND.
- GAP: count `GAP_CYCLES` cycles with `dec_valid`=0, then return to SEND.
- FIN: `done`=1 for exactly one cycle, then IDLE.
- `start` while `busy`=1 is ignored; the latched code is unaffected by `code` changes mid-transaction.
- Counter width is `$clog2(NUM_DIGITS+2)`. The gap counter width is `$clog2(GAP_CYCLES+1)`, minimum 1.

## Timing
- Reset value of every output (`dec`, `dec_valid`, `busy`, `done`, `err`) is 0. The buffer is cleared and the state is IDLE.
- Reset mid-transaction aborts immediately and asynchronously; no partial `done`.
- With `start` accepted at edge 0, digit k is valid in cycle 1 + k·(GAP_CYCLES+1).
- `busy` is 1 from cycle 1 through the last digit cycle.
- `done` is 1 in the cycle after the last digit. `busy`=0 in that cycle.
- A `start` sampled in the `done` cycle is accepted, giving back-to-back transactions with no bubble beyond FIN.
- `err` is asserted in cycle 1 after a rejected start. `busy` stays 0.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `CODE_SENDER_CHECK_EN` defined: after the last code digit, one extra check digit is sent, equal to (sum of all digits) mod 10.
  - It follows the same gap rule as data digits.
  - `done` moves one slot later.
  - The mod-10 sum is accumulated during SEND, 5 bits wide, and reduced each step.
- Not defined: exactly `NUM_DIGITS` digits are sent and no checksum logic exists.

## Structure
- Package `code_sender_pkg`:
  - state enum `{IDLE, SEND, GAP, FIN}`;
  - `DIGIT_W`=4;
  - `MAX_DIGIT`=9.
- Sub-module `code_sender_cksum` holds the mod-10 accumulator: clear, add digit, output check digit. It is instantiated only under `CODE_SENDER_CHECK_EN`.

## Test plan
- Defaults, `code`=16'h0568, `start` at edge 0:
  - `dec`=0,5,6,8 with `dec_valid`=1 in cycles 1–4;
  - `done` in cycle 5.
  - When fed straight into the lock, the lock's `y`=1 in the cycle after the fourth digit is registered.
- `GAP_CYCLES`=2, `code`=16'h1234: digits 1,2,3,4 in cycles 1,4,7,10 with `dec_valid`=0 and `dec`=0 between them; `done` in cycle 11.
- `code`=16'h05A8 with `start`: `err`=1 in cycle 1 only; `busy` and `dec_valid` stay 0.
- `start` re-pulsed in cycle 2 with `code`=16'h9999 during a 16'h0568 send: the stream is still 0,5,6,8. A `start` held in the `done` cycle begins 9,9,9,9 in the next cycle.
- `rst` pulsed asynchronously mid-cycle 2: all outputs are 0 immediately. A fresh start afterwards sends all four digits.
- With `CODE_SENDER_CHECK_EN` and `code`=16'h0568: digits 0,5,6,8 in cycles 1–4, then 9 in cycle 5 (19 mod 10); `done` in cycle 6.
